// File: rtl/e203_lsu_biu_ost_buf.sv
// LSU-to-BIU ICB buffer: one registered command slice, an in-order response FIFO,
// an upstream outstanding limit, activity reporting and spurious-response detection.
module e203_lsu_biu_ost_buf #(
    parameter int unsigned OST_DEPTH = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_icb_cmd_valid,
    output logic              i_icb_cmd_ready,
    input  logic [AW-1:0]     i_icb_cmd_addr,
    input  logic              i_icb_cmd_read,
    input  logic [DW-1:0]     i_icb_cmd_wdata,
    input  logic [DW/8-1:0]   i_icb_cmd_wmask,
    input  logic              i_icb_cmd_lock,
    input  logic              i_icb_cmd_excl,
    input  logic [1:0]        i_icb_cmd_size,

    output logic              i_icb_rsp_valid,
    input  logic              i_icb_rsp_ready,
    output logic              i_icb_rsp_err,
    output logic              i_icb_rsp_excl_ok,
    output logic [DW-1:0]     i_icb_rsp_rdata,

    output logic              o_icb_cmd_valid,
    input  logic              o_icb_cmd_ready,
    output logic [AW-1:0]     o_icb_cmd_addr,
    output logic              o_icb_cmd_read,
    output logic [DW-1:0]     o_icb_cmd_wdata,
    output logic [DW/8-1:0]   o_icb_cmd_wmask,
    output logic              o_icb_cmd_lock,
    output logic              o_icb_cmd_excl,
    output logic [1:0]        o_icb_cmd_size,

    input  logic              o_icb_rsp_valid,
    output logic              o_icb_rsp_ready,
    input  logic              o_icb_rsp_err,
    input  logic              o_icb_rsp_excl_ok,
    input  logic [DW-1:0]     o_icb_rsp_rdata,

    output logic              ost_active,
    output logic              ost_err
);

    localparam int unsigned   MW       = DW / 8;
    localparam int unsigned   CW       = $clog2(OST_DEPTH + 1);
    localparam int unsigned   PW       = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(OST_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(OST_DEPTH - 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          read;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        logic          lock;
        logic          excl;
        logic [1:0]    size;
    } cmd_t;

    typedef struct packed {
        logic          err;
        logic          excl_ok;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic          cmd_vld_q, cmd_vld_d;
    cmd_t          cmd_q;
    logic [CW-1:0] up_cnt_q, up_cnt_d;
    logic [CW-1:0] dn_cnt_q, dn_cnt_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          ost_err_q, ost_err_d;
    rsp_t          fifo_q [OST_DEPTH];

    logic up_cmd_hs;
    logic dn_cmd_hs;
    logic dn_rsp_hs;
    logic rsp_spurious;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    cmd_t cmd_in;
    rsp_t rsp_in;
    rsp_t rsp_head;

    assign cmd_in = '{addr:  i_icb_cmd_addr,  read: i_icb_cmd_read,
                      wdata: i_icb_cmd_wdata, wmask: i_icb_cmd_wmask,
                      lock:  i_icb_cmd_lock,  excl: i_icb_cmd_excl,
                      size:  i_icb_cmd_size};
    assign rsp_in = '{err: o_icb_rsp_err, excl_ok: o_icb_rsp_excl_ok, rdata: o_icb_rsp_rdata};

    assign fifo_full  = (fifo_cnt_q == DEPTH_C);
    assign fifo_empty = (fifo_cnt_q == '0);

    // Only combinational path through the block: o_icb_cmd_ready -> i_icb_cmd_ready.
    assign i_icb_cmd_ready = ~rst & (~cmd_vld_q | o_icb_cmd_ready) & (up_cnt_q < DEPTH_C);
    assign o_icb_rsp_ready = ~fifo_full;

    assign up_cmd_hs    = i_icb_cmd_valid & i_icb_cmd_ready;
    assign dn_cmd_hs    = cmd_vld_q & o_icb_cmd_ready;
    assign dn_rsp_hs    = o_icb_rsp_valid & o_icb_rsp_ready;
    assign rsp_spurious = dn_rsp_hs & (dn_cnt_q == '0);
    assign fifo_push    = dn_rsp_hs & ~rsp_spurious;
    assign fifo_pop     = ~fifo_empty & i_icb_rsp_ready;

    always_comb begin
        cmd_vld_d  = cmd_vld_q;
        up_cnt_d   = up_cnt_q;
        dn_cnt_d   = dn_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        ost_err_d  = ost_err_q;

        if (up_cmd_hs) begin
            cmd_vld_d = 1'b1;
        end else if (dn_cmd_hs) begin
            cmd_vld_d = 1'b0;
        end

        case ({up_cmd_hs, fifo_pop})
            2'b10:   up_cnt_d = up_cnt_q + CW'(1);
            2'b01:   up_cnt_d = up_cnt_q - CW'(1);
            default: up_cnt_d = up_cnt_q;
        endcase

        case ({dn_cmd_hs, fifo_push})
            2'b10:   dn_cnt_d = dn_cnt_q + CW'(1);
            2'b01:   dn_cnt_d = dn_cnt_q - CW'(1);
            default: dn_cnt_d = dn_cnt_q;
        endcase

        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // Pointers wrap modulo OST_DEPTH, which need not be a power of two.
        if (fifo_push) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
        end
        if (fifo_pop) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
        end

        if (rsp_spurious) begin
            ost_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld_q  <= 1'b0;
            up_cnt_q   <= '0;
            dn_cnt_q   <= '0;
            fifo_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ost_err_q  <= 1'b0;
        end else begin
            cmd_vld_q  <= cmd_vld_d;
            up_cnt_q   <= up_cnt_d;
            dn_cnt_q   <= dn_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ost_err_q  <= ost_err_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the control state.
    always_ff @(posedge clk) begin
        if (up_cmd_hs) begin
            cmd_q <= cmd_in;
        end
        if (fifo_push) begin
            fifo_q[wptr_q] <= rsp_in;
        end
    end

    assign rsp_head = fifo_q[rptr_q];

    assign o_icb_cmd_valid   = cmd_vld_q;
    assign o_icb_cmd_addr    = cmd_q.addr;
    assign o_icb_cmd_read    = cmd_q.read;
    assign o_icb_cmd_wdata   = cmd_q.wdata;
    assign o_icb_cmd_wmask   = cmd_q.wmask;
    assign o_icb_cmd_lock    = cmd_q.lock;
    assign o_icb_cmd_excl    = cmd_q.excl;
    assign o_icb_cmd_size    = cmd_q.size;

    assign i_icb_rsp_valid   = ~fifo_empty;
    assign i_icb_rsp_err     = rsp_head.err;
    assign i_icb_rsp_excl_ok = rsp_head.excl_ok;
    assign i_icb_rsp_rdata   = rsp_head.rdata;

    assign ost_active = cmd_vld_q | (up_cnt_q != '0);
    assign ost_err    = ost_err_q;

endmodule

// File: tb/tb_e203_lsu_biu_ost_buf.sv
// Directed and randomized bench for e203_lsu_biu_ost_buf against a queue-based model.
module tb_e203_lsu_biu_ost_buf;

    localparam int unsigned D  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          read;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        logic          lock;
        logic          excl;
        logic [1:0]    size;
    } cmd_t;

    typedef struct packed {
        logic          err;
        logic          excl_ok;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic i_icb_cmd_valid, i_icb_cmd_ready, i_icb_cmd_read, i_icb_cmd_lock, i_icb_cmd_excl;
    logic [AW-1:0] i_icb_cmd_addr;
    logic [DW-1:0] i_icb_cmd_wdata;
    logic [MW-1:0] i_icb_cmd_wmask;
    logic [1:0]    i_icb_cmd_size;
    logic i_icb_rsp_valid, i_icb_rsp_ready, i_icb_rsp_err, i_icb_rsp_excl_ok;
    logic [DW-1:0] i_icb_rsp_rdata;
    logic o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read, o_icb_cmd_lock, o_icb_cmd_excl;
    logic [AW-1:0] o_icb_cmd_addr;
    logic [DW-1:0] o_icb_cmd_wdata;
    logic [MW-1:0] o_icb_cmd_wmask;
    logic [1:0]    o_icb_cmd_size;
    logic o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err, o_icb_rsp_excl_ok;
    logic [DW-1:0] o_icb_rsp_rdata;
    logic ost_active, ost_err;

    always #5 clk = ~clk;

    e203_lsu_biu_ost_buf #(.OST_DEPTH(D), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
        .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
        .i_icb_cmd_wdata(i_icb_cmd_wdata), .i_icb_cmd_wmask(i_icb_cmd_wmask),
        .i_icb_cmd_lock(i_icb_cmd_lock), .i_icb_cmd_excl(i_icb_cmd_excl),
        .i_icb_cmd_size(i_icb_cmd_size),
        .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
        .i_icb_rsp_err(i_icb_rsp_err), .i_icb_rsp_excl_ok(i_icb_rsp_excl_ok),
        .i_icb_rsp_rdata(i_icb_rsp_rdata),
        .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
        .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
        .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
        .o_icb_cmd_lock(o_icb_cmd_lock), .o_icb_cmd_excl(o_icb_cmd_excl),
        .o_icb_cmd_size(o_icb_cmd_size),
        .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
        .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_excl_ok(o_icb_rsp_excl_ok),
        .o_icb_rsp_rdata(o_icb_rsp_rdata),
        .ost_active(ost_active), .ost_err(ost_err)
    );

    // Reference model: buffered command, in-flight counts, response queue, sticky error.
    cmd_t slot_q[$];
    rsp_t rsp_q[$];
    int   up_m, dn_m;
    logic err_m;
    bit   known;
    logic e_cready;
    int   n_pass, n_tot;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_idle();
        i_icb_cmd_valid   = 1'b0;
        i_icb_cmd_addr    = $urandom;
        i_icb_cmd_read    = 1'($urandom);
        i_icb_cmd_wdata   = $urandom;
        i_icb_cmd_wmask   = 4'($urandom);
        i_icb_cmd_lock    = 1'b0;
        i_icb_cmd_excl    = 1'b0;
        i_icb_cmd_size    = 2'b10;
        i_icb_rsp_ready   = 1'b1;
        o_icb_cmd_ready   = 1'b1;
        o_icb_rsp_valid   = 1'b0;
        o_icb_rsp_err     = 1'b0;
        o_icb_rsp_excl_ok = 1'b0;
        o_icb_rsp_rdata   = $urandom;
    endtask

    task automatic sample_check();
        #3;
        e_cready = !rst && (slot_q.size() == 0 || o_icb_cmd_ready) && (up_m < int'(D));
        chk("i_cmd_ready", 128'(i_icb_cmd_ready), 128'(e_cready));
        if (known) begin
            chk("o_cmd_valid", 128'(o_icb_cmd_valid), 128'(slot_q.size() != 0));
            if (slot_q.size() != 0)
                chk("o_cmd_payload", 128'(cmd_t'({o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata,
                    o_icb_cmd_wmask, o_icb_cmd_lock, o_icb_cmd_excl, o_icb_cmd_size})), 128'(slot_q[0]));
            chk("i_rsp_valid", 128'(i_icb_rsp_valid), 128'(rsp_q.size() != 0));
            if (rsp_q.size() != 0)
                chk("i_rsp_payload", 128'(rsp_t'({i_icb_rsp_err, i_icb_rsp_excl_ok, i_icb_rsp_rdata})),
                    128'(rsp_q[0]));
            chk("o_rsp_ready", 128'(o_icb_rsp_ready), 128'(rsp_q.size() < D));
            chk("ost_active", 128'(ost_active), 128'(slot_q.size() != 0 || up_m != 0));
            chk("ost_err", 128'(ost_err), 128'(err_m));
        end
    endtask

    task automatic advance();
        logic uhs, dhs, rin, pop;
        cmd_t c;
        rsp_t r;
        uhs = i_icb_cmd_valid && e_cready;
        dhs = slot_q.size() != 0 && o_icb_cmd_ready;
        rin = o_icb_rsp_valid && rsp_q.size() < D;
        pop = rsp_q.size() != 0 && i_icb_rsp_ready;
        c = cmd_t'({i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_cmd_wmask,
                    i_icb_cmd_lock, i_icb_cmd_excl, i_icb_cmd_size});
        r = rsp_t'({o_icb_rsp_err, o_icb_rsp_excl_ok, o_icb_rsp_rdata});
        @(posedge clk);
        if (rst) begin
            slot_q.delete(); rsp_q.delete();
            up_m = 0; dn_m = 0; err_m = 1'b0; known = 1'b1;
        end else begin
            if (rin) begin
                if (dn_m == 0) err_m = 1'b1;
                else begin dn_m--; rsp_q.push_back(r); end
            end
            if (pop) begin void'(rsp_q.pop_front()); up_m--; end
            if (dhs) begin void'(slot_q.pop_front()); dn_m++; end
            if (uhs) begin slot_q.push_back(c); up_m++; end
        end
        #1;
    endtask

    task automatic cyc();
        sample_check();
        advance();
    endtask

    initial begin
        int issued, got, resp_n;
        n_pass = 0; n_tot = 0; known = 1'b0;
        up_m = 0; dn_m = 0; err_m = 1'b0;

        // Reset held for three cycles, then released.
        rst = 1'b1;
        set_idle();
        repeat (3) cyc();
        rst = 1'b0;
        sample_check();
        chk("rst_release_cmd_ready", 128'(i_icb_cmd_ready), 128'(1'b1));
        chk("rst_release_ost_active", 128'(ost_active), 128'(1'b0));
        advance();

        // Single load with delayed BIU acceptance and response.
        set_idle();
        i_icb_cmd_valid = 1'b1; i_icb_cmd_read = 1'b1; i_icb_cmd_addr = 32'h8000_0010;
        o_icb_cmd_ready = 1'b0;
        cyc();
        i_icb_cmd_valid = 1'b0; o_icb_cmd_ready = 1'b1;
        sample_check();
        chk("load_o_cmd_valid", 128'(o_icb_cmd_valid), 128'(1'b1));
        chk("load_o_cmd_addr", 128'(o_icb_cmd_addr), 128'(32'h8000_0010));
        advance();
        cyc();
        o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'hDEAD_BEEF;
        cyc();
        o_icb_rsp_valid = 1'b0;
        sample_check();
        chk("load_i_rsp_valid", 128'(i_icb_rsp_valid), 128'(1'b1));
        chk("load_i_rsp_rdata", 128'(i_icb_rsp_rdata), 128'(32'hDEAD_BEEF));
        chk("load_i_rsp_err", 128'(i_icb_rsp_err), 128'(1'b0));
        advance();

        // Streaming stores; responses must come back upstream in issue order.
        set_idle();
        issued = 0; got = 0; resp_n = 0;
        for (int k = 0; k < 80 && got < 8; k++) begin
            i_icb_cmd_valid = (issued < 8);
            i_icb_cmd_read  = 1'b0;
            i_icb_cmd_addr  = 32'h0000_1000 + 32'(issued * 4);
            i_icb_cmd_wdata = 32'hA000_0000 + 32'(issued);
            o_icb_rsp_valid = (dn_m > 0);
            o_icb_rsp_rdata = 32'h5000_0000 + 32'(resp_n);
            sample_check();
            if (rsp_q.size() != 0 && i_icb_rsp_ready) begin
                chk("stream_order", 128'(i_icb_rsp_rdata), 128'(32'h5000_0000 + 32'(got)));
                got++;
            end
            if (i_icb_cmd_valid && e_cready) issued++;
            if (o_icb_rsp_valid && rsp_q.size() < D && dn_m > 0) resp_n++;
            advance();
        end
        chk("stream_count", 128'(got), 128'(8));

        // Back-pressure: upstream not ready, FIFO fills and blocks new commands.
        set_idle();
        i_icb_rsp_ready = 1'b0;
        issued = 0; resp_n = 0;
        for (int k = 0; k < 10; k++) begin
            i_icb_cmd_valid = (issued < 2);
            o_icb_rsp_valid = (dn_m > 0);
            o_icb_rsp_rdata = 32'h7700_0000 + 32'(resp_n);
            sample_check();
            if (i_icb_cmd_valid && e_cready) issued++;
            if (o_icb_rsp_valid && rsp_q.size() < D && dn_m > 0) resp_n++;
            advance();
        end
        i_icb_cmd_valid = 1'b1; o_icb_rsp_valid = 1'b0;
        sample_check();
        chk("bp_cmd_ready_low", 128'(i_icb_cmd_ready), 128'(1'b0));
        chk("bp_fifo_full", 128'(o_icb_rsp_ready), 128'(1'b0));
        advance();
        i_icb_cmd_valid = 1'b0; i_icb_rsp_ready = 1'b1;
        sample_check();
        chk("bp_drain0", 128'(i_icb_rsp_rdata), 128'(32'h7700_0000));
        advance();
        sample_check();
        chk("bp_drain1", 128'(i_icb_rsp_rdata), 128'(32'h7700_0001));
        advance();
        sample_check();
        chk("bp_cmd_ready_back", 128'(i_icb_cmd_ready), 128'(1'b1));
        advance();

        // Spurious response with nothing outstanding.
        set_idle();
        o_icb_rsp_valid = 1'b1;
        cyc();
        o_icb_rsp_valid = 1'b0;
        sample_check();
        chk("spur_err_set", 128'(ost_err), 128'(1'b1));
        chk("spur_no_rsp", 128'(i_icb_rsp_valid), 128'(1'b0));
        advance();
        repeat (3) cyc();
        i_icb_cmd_valid = 1'b1; i_icb_cmd_addr = 32'h0000_2000;
        cyc();
        i_icb_cmd_valid = 1'b0;
        cyc();
        o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = 32'h1234_5678;
        cyc();
        o_icb_rsp_valid = 1'b0;
        sample_check();
        chk("spur_err_sticky", 128'(ost_err), 128'(1'b1));
        chk("spur_after_rdata", 128'(i_icb_rsp_rdata), 128'(32'h1234_5678));
        advance();

        // Error/exclusive propagation.
        set_idle();
        i_icb_cmd_valid = 1'b1; i_icb_cmd_excl = 1'b1;
        cyc();
        i_icb_cmd_valid = 1'b0;
        cyc();
        o_icb_rsp_valid = 1'b1; o_icb_rsp_err = 1'b1; o_icb_rsp_excl_ok = 1'b1;
        cyc();
        o_icb_rsp_valid = 1'b0;
        sample_check();
        chk("errprop_err", 128'(i_icb_rsp_err), 128'(1'b1));
        chk("errprop_excl_ok", 128'(i_icb_rsp_excl_ok), 128'(1'b1));
        advance();

        // Reset while a command is pending downstream.
        set_idle();
        i_icb_cmd_valid = 1'b1; o_icb_cmd_ready = 1'b0;
        cyc();
        i_icb_cmd_valid = 1'b0; rst = 1'b1;
        sample_check();
        chk("midrst_cmd_ready_low", 128'(i_icb_cmd_ready), 128'(1'b0));
        advance();
        rst = 1'b0;
        sample_check();
        chk("midrst_o_cmd_valid", 128'(o_icb_cmd_valid), 128'(1'b0));
        chk("midrst_i_rsp_valid", 128'(i_icb_rsp_valid), 128'(1'b0));
        chk("midrst_ost_active", 128'(ost_active), 128'(1'b0));
        chk("midrst_ost_err", 128'(ost_err), 128'(1'b0));
        advance();

        // Randomized traffic with occasional spurious responses and resets.
        for (int k = 0; k < 600; k++) begin
            rst               = ($urandom % 150 == 0);
            i_icb_cmd_valid   = 1'($urandom);
            i_icb_cmd_addr    = $urandom;
            i_icb_cmd_read    = 1'($urandom);
            i_icb_cmd_wdata   = $urandom;
            i_icb_cmd_wmask   = 4'($urandom);
            i_icb_cmd_lock    = 1'($urandom);
            i_icb_cmd_excl    = 1'($urandom);
            i_icb_cmd_size    = 2'($urandom);
            o_icb_cmd_ready   = ($urandom % 4 != 0);
            i_icb_rsp_ready   = ($urandom % 4 != 0);
            o_icb_rsp_valid   = (dn_m > 0) ? 1'($urandom) : ($urandom % 40 == 0);
            o_icb_rsp_err     = 1'($urandom);
            o_icb_rsp_excl_ok = 1'($urandom);
            o_icb_rsp_rdata   = $urandom;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
